// File: rtl/eq_display_pkg.sv
// Shared definitions for the EQ display path: ASCII constants and the
// converter FSM state type.
package eq_display_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } conv_state_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/value_to_ascii2.sv
// Binary field value to two-character ASCII string, using iterative
// divide-by-10 (repeated subtraction) with a start/busy handshake.
module value_to_ascii2
    import eq_display_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value_in,
    output logic             busy,
    output logic             load_string,
    output logic [15:0]      string_out
);

    localparam int RW = WIDTH + 1;

    conv_state_t     state;
    logic [RW-1:0]   rem;
    logic [3:0]      tens;
    logic            neg;
    logic            ovf;

    logic            neg_now;
    logic [RW-1:0]   ext_now;
    logic [RW-1:0]   mag_now;
    logic            ovf_now;
    logic [31:0]     mag_ext;
    logic [31:0]     rem_ext;
    logic [7:0]      left_char;
    logic [7:0]      right_char;

    // One extra bit so |most-negative| still fits in the magnitude.
    always_comb begin
        neg_now = (SIGNED != 0) && value_in[WIDTH-1];
        ext_now = {neg_now, value_in};
        mag_now = neg_now ? (~ext_now + {{(RW-1){1'b0}}, 1'b1}) : ext_now;
        mag_ext = 32'(mag_now);
        if (SIGNED != 0)
            ovf_now = (mag_ext > 32'd9);
        else
            ovf_now = (mag_ext > 32'd99);
    end

    assign rem_ext = 32'(rem);

    always_comb begin
        left_char  = ASCII_SPACE;
        right_char = ascii_digit(rem_ext[3:0]);
        if (SIGNED != 0) begin
            if (neg)
                left_char = ASCII_MINUS;
            else if (rem_ext == 32'd0)
                left_char = ASCII_SPACE;
            else
                left_char = ASCII_PLUS;
        end else begin
            if ((tens == 4'd0) && (BLANK_LZ != 0))
                left_char = ASCII_SPACE;
            else
                left_char = ascii_digit(tens);
        end
        if (ovf) begin
            left_char  = ASCII_STAR;
            right_char = ASCII_STAR;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            load_string <= 1'b0;
            string_out  <= 16'h0000;
            rem         <= '0;
            tens        <= 4'd0;
            neg         <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            load_string <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CONV;
                        busy  <= 1'b1;
                        rem   <= ovf_now ? '0 : mag_now;
                        tens  <= 4'd0;
                        neg   <= neg_now;
                        ovf   <= ovf_now;
                    end
                end
                CONV: begin
                    if (rem_ext >= 32'd10) begin
                        rem  <= rem - RW'(10);
                        tens <= tens + 4'd1;
                    end else begin
                        // Output registered on entry so it is valid during EMIT.
                        state       <= EMIT;
                        load_string <= 1'b1;
                        string_out  <= {left_char, right_char};
                    end
                end
                EMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_value_to_ascii2.sv
// Scoreboard bench for value_to_ascii2: three configurations (unsigned blanked,
// unsigned zero-padded, signed) share clock and reset.
module tb_value_to_ascii2;

    typedef struct {
        logic [15:0] s;
        int          cyc;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic [2:0]  start;
    logic [7:0]  val [3];
    logic [2:0]  busy;
    logic [2:0]  ld;
    logic [15:0] str [3];

    exp_t q [3][$];
    int   cyc;
    int   checks;
    int   errors;

    value_to_ascii2 #(.WIDTH(8), .SIGNED(0), .BLANK_LZ(1)) u_unb (
        .Clk(Clk), .Reset(Reset), .start(start[0]), .value_in(val[0]),
        .busy(busy[0]), .load_string(ld[0]), .string_out(str[0]));

    value_to_ascii2 #(.WIDTH(8), .SIGNED(0), .BLANK_LZ(0)) u_zp (
        .Clk(Clk), .Reset(Reset), .start(start[1]), .value_in(val[1]),
        .busy(busy[1]), .load_string(ld[1]), .string_out(str[1]));

    value_to_ascii2 #(.WIDTH(8), .SIGNED(1), .BLANK_LZ(1)) u_sg (
        .Clk(Clk), .Reset(Reset), .start(start[2]), .value_in(val[2]),
        .busy(busy[2]), .load_string(ld[2]), .string_out(str[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every load_string pulse must match the oldest expectation.
    always @(negedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 3; i++) begin
                if (ld[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_load[%0d]", i), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        chk($sformatf("string[%0d]", i), {16'h0, str[i]}, {16'h0, e.s});
                        chk($sformatf("load_cycle[%0d]", i), cyc, e.cyc);
                    end
                end
            end
        end
    end

    // One conversion: start in cycle 0, busy checked cycles 1..T, idle at T+1.
    task automatic convert(input int sel, input logic [7:0] v,
                           input logic [15:0] exp_s, input int t);
        exp_t e;
        @(negedge Clk);
        start[sel] = 1'b1;
        val[sel]   = v;
        e.s   = exp_s;
        e.cyc = cyc + t;
        q[sel].push_back(e);
        @(negedge Clk);
        start[sel] = 1'b0;
        val[sel]   = 8'hC3;
        for (int k = 1; k <= t; k++) begin
            chk($sformatf("busy_hi[%0d] v=%0d k=%0d", sel, v, k), {31'h0, busy[sel]}, 32'd1);
            @(negedge Clk);
        end
        chk($sformatf("busy_lo[%0d] v=%0d", sel, v), {31'h0, busy[sel]}, 32'd0);
        chk($sformatf("drained[%0d] v=%0d", sel, v), q[sel].size(), 32'd0);
    endtask

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        start  = 3'b000;
        for (int i = 0; i < 3; i++) val[i] = 8'h00;
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy[%0d]", i), {31'h0, busy[i]}, 32'd0);
            chk($sformatf("rst_load[%0d]", i), {31'h0, ld[i]}, 32'd0);
            chk($sformatf("rst_str[%0d]", i), {16'h0, str[i]}, 32'h0000);
        end
        Reset = 1'b0;

        convert(0, 8'd57,  16'h3537, 7);
        convert(0, 8'd7,   16'h2037, 2);
        convert(1, 8'd7,   16'h3037, 2);
        convert(0, 8'd99,  16'h3939, 11);
        convert(0, 8'd100, 16'h2A2A, 2);
        convert(0, 8'd255, 16'h2A2A, 2);
        convert(0, 8'd0,   16'h2030, 2);
        convert(0, 8'd10,  16'h3130, 3);
        convert(1, 8'd0,   16'h3030, 2);
        convert(1, 8'd42,  16'h3432, 6);
        convert(2, 8'hFD,  16'h2D33, 2);
        convert(2, 8'd5,   16'h2B35, 2);
        convert(2, 8'd0,   16'h2030, 2);
        convert(2, 8'h80,  16'h2A2A, 2);
        convert(2, 8'd10,  16'h2A2A, 2);
        convert(2, 8'hF7,  16'h2D39, 2);

        // Start re-pulsed while busy must be ignored.
        @(negedge Clk);
        start[0] = 1'b1; val[0] = 8'd57;
        e.s = 16'h3537; e.cyc = cyc + 7; q[0].push_back(e);
        @(negedge Clk);
        start[0] = 1'b0; val[0] = 8'd0;
        @(negedge Clk);
        start[0] = 1'b1; val[0] = 8'd12;
        @(negedge Clk);
        start[0] = 1'b0;
        repeat (8) @(negedge Clk);
        chk("ignored_start_busy", {31'h0, busy[0]}, 32'd0);
        chk("ignored_start_drained", q[0].size(), 32'd0);

        // Reset in a CONV cycle aborts silently.
        @(negedge Clk);
        start[0] = 1'b1; val[0] = 8'd57;
        @(negedge Clk);
        start[0] = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_busy", {31'h0, busy[0]}, 32'd0);
        chk("abort_load", {31'h0, ld[0]}, 32'd0);
        chk("abort_str", {16'h0, str[0]}, 32'h0000);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        chk("abort_idle", {31'h0, busy[0]}, 32'd0);

        // Start held high: one conversion every T+1 = 3 cycles.
        @(negedge Clk);
        start[0] = 1'b1; val[0] = 8'd5;
        for (int k = 0; k < 3; k++) begin
            e.s = 16'h2035; e.cyc = cyc + 2 + 3 * k; q[0].push_back(e);
        end
        repeat (3) @(negedge Clk);
        chk("held_idle_gap", {31'h0, busy[0]}, 32'd0);
        repeat (4) @(negedge Clk);
        start[0] = 1'b0;
        repeat (4) @(negedge Clk);
        chk("held_drained", q[0].size(), 32'd0);
        chk("held_final_busy", {31'h0, busy[0]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/value_to_ascii2.md
Name: value_to_ascii2

Overview:
- Converts a binary field value (band gain in dB, band index, Q setting) into a two-character ASCII string.
- Sits directly upstream of the two-character string sprite stage.
- Drives that stage's 16-bit string input and its load strobe.
- Iterative divide-by-10 (repeated subtraction) with a start/busy handshake; one conversion at a time.

Parameters:
- WIDTH, 8, bit width of value_in (2..10).
- SIGNED, 0, 0 = unsigned two-digit mode (0..99); 1 = two's-complement sign+digit mode (-9..+9).
- BLANK_LZ, 1, unsigned mode only: 1 = tens digit 0 is shown as space (0x20), 0 = shown as '0'.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request; sampled only when busy=0
- value_in  input  WIDTH  value to convert; captured on the accepted start cycle
- busy  output  1  conversion in progress; start ignored while high
- load_string  output  1  one-cycle strobe; string_out valid and stable from this cycle on
- string_out  output  16  [15:8] = left character, [7:0] = right character; held until next load_string

Behaviour:
- Reset: state IDLE; busy=0, load_string=0, string_out=16'h0000, internal rem/tens/flags cleared. Reset during CONV/EMIT aborts with no load_string pulse.
- FSM states: IDLE, CONV, EMIT.
- IDLE -> CONV on start=1.
  - Capture the magnitude into rem: unsigned = value_in; signed = |value_in|, with the negative flag stored.
  - tens := 0.
  - Overflow flag set if the magnitude is >99 (unsigned) or >9 (signed). On overflow, rem is forced to 0.
- CONV, one step per cycle:
  - if rem >= 10: rem := rem - 10, tens := tens + 1;
  - else: -> EMIT.
  - Signed mode never iterates; its magnitude is always <10 or overflowed.
- EMIT: register string_out, assert load_string for exactly this cycle, then -> IDLE.
- busy=1 in every cycle where state != IDLE, including the EMIT cycle.
- Latency: start accepted in cycle 0; load_string high in cycle T = tens + 2.
  - Maximum T is 11 (value 99).
  - Overflow and signed-mode results always have T = 2.
- Back-to-back: start may be reasserted in cycle T+1 and is accepted there. A start held high continuously restarts a conversion every T+1 cycles.
- Character encoding:
  - Digits are 8'h30 + d.
  - Unsigned mode:
    - left = tens digit, or space if tens=0 and BLANK_LZ=1;
    - right = rem digit.
  - Signed mode:
    - left = '-' (0x2D) if negative, '+' (0x2B) if positive, space if zero;
    - right = magnitude digit.
  - Overflow in either mode: string_out = 16'h2A2A ("**").
- Width rules:
  - rem is WIDTH+1 bits, so the magnitude of the most-negative signed value is representable.
  - tens is 4 bits; it cannot exceed 9 because values >99 take the overflow path.
- value_in changes while busy: no effect; only the captured copy is used.

Decomposition:
- Shared package eq_display_pkg holds:
  - ASCII constants: ASCII_ZERO, ASCII_SPACE, ASCII_PLUS, ASCII_MINUS, ASCII_STAR;
  - the FSM state enum conv_state_t (IDLE, CONV, EMIT).
- No sub-module; the subtract/compare datapath stays inline in this block.

Test Plan:
- Unsigned, BLANK_LZ=1, start with value_in=57 -> load_string in cycle 7 only, string_out=16'h3537, busy high cycles 1..7.
- Unsigned, value 7 with BLANK_LZ=1 -> 16'h2037 at cycle 2; same value with BLANK_LZ=0 -> 16'h3037.
- Unsigned, value 99 -> 16'h3939 at cycle 11; value 100 -> 16'h2A2A at cycle 2.
- SIGNED=1, WIDTH=8: values -3, +5, 0, -128, +10 -> 16'h2D33, 16'h2B35, 16'h2030, 16'h2A2A, 16'h2A2A, each at cycle 2.
- Protocol: start pulsed again during busy -> ignored, exactly one load_string. Reset asserted in a CONV cycle -> no load_string, string_out=16'h0000, busy=0 next cycle. Start held high -> conversions accepted every T+1 cycles.
